// File: rtl/sot_frame_aligner_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sot_frame_aligner_gen_pkg
//  Purpose  : Shared types and helpers for the SoT frame aligner: lock state
//             encoding, one-hot index decoder and frame-size constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sot_frame_aligner_gen_pkg;

  localparam int FRAME_SIZE_SDR = 8;
  localparam int FRAME_SIZE_DDR = 16;

  // The decoder is sized for the widest supported frame; narrower frames are
  // zero-extended before decoding.
  localparam int ONEHOT_MAX_W = FRAME_SIZE_DDR;
  localparam int ONEHOT_IDX_W = $clog2(ONEHOT_MAX_W);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    VERIFY   = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } lock_state_e;

  typedef struct packed {
    logic                    valid;
    logic [ONEHOT_IDX_W-1:0] index;
  } onehot_t;

  // valid is set only when exactly one bit is high; index is then its position.
  function automatic onehot_t onehot_index(input logic [ONEHOT_MAX_W-1:0] vec);
    onehot_t res;
    res.valid = (vec != '0) && ((vec & (vec - 16'd1)) == '0);
    res.index = '0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if (vec[i]) res.index = i[ONEHOT_IDX_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sot_frame_aligner_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : sot_frame_aligner_gen_if
//  Purpose  : Bundles the aligner's data, control and status signals.
//  Ports    : master drives sbits_i, start_of_frame_i, mask_i, clear_err_i,
//             aligned_count_to_ready_i and observes the status outputs;
//             slave is the aligner side.
//  Revision : 1.0  initial release
// ============================================================================
interface sot_frame_aligner_gen_if
  import sot_frame_aligner_gen_pkg::*;
#(
  parameter int FRAME_SIZE = FRAME_SIZE_SDR,
  parameter int NUM_LANES  = 8,
  parameter int SLIP_W     = $clog2(FRAME_SIZE),
  parameter int ERR_CNT_W  = 16
);

  logic [NUM_LANES*FRAME_SIZE-1:0] sbits_i;
  logic [FRAME_SIZE-1:0]           start_of_frame_i;
  logic                            mask_i;
  logic                            clear_err_i;
  logic [11:0]                     aligned_count_to_ready_i;
  logic [NUM_LANES*FRAME_SIZE-1:0] sbits_o;
  logic [SLIP_W-1:0]               slip_o;
  logic                            sot_is_aligned_o;
  logic                            sot_unstable_o;
  logic [ERR_CNT_W-1:0]            sot_err_cnt_o;

  modport master (
    output sbits_i, start_of_frame_i, mask_i, clear_err_i, aligned_count_to_ready_i,
    input  sbits_o, slip_o, sot_is_aligned_o, sot_unstable_o, sot_err_cnt_o
  );

  modport slave (
    input  sbits_i, start_of_frame_i, mask_i, clear_err_i, aligned_count_to_ready_i,
    output sbits_o, slip_o, sot_is_aligned_o, sot_unstable_o, sot_err_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/sot_frame_aligner_gen_frame_slip_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sot_frame_aligner_gen_frame_slip_lane
//  Purpose  : Word-aligns one S-bit lane: keeps the previous frame, selects
//             FRAME_SIZE bits out of {current, previous} at the slip offset
//             and registers the result.
//  Ports    : clock, reset_n_i  - frame clock, async active-low reset
//             lane_i            - raw lane frame
//             slip_i            - bit offset into the two-frame window
//             mask_i            - zero the registered output
//             lane_o            - aligned lane frame (1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module sot_frame_aligner_gen_frame_slip_lane
  import sot_frame_aligner_gen_pkg::*;
#(
  parameter int FRAME_SIZE = FRAME_SIZE_SDR,
  parameter int SLIP_W     = $clog2(FRAME_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset_n_i,
  input  logic [FRAME_SIZE-1:0] lane_i,
  input  logic [SLIP_W-1:0]     slip_i,
  input  logic                  mask_i,
  output logic [FRAME_SIZE-1:0] lane_o
);

  logic [FRAME_SIZE-1:0]   prev_q;
  logic [FRAME_SIZE-1:0]   lane_q;
  logic [2*FRAME_SIZE-1:0] window_d;

  // Current frame in the upper half so slip 0 yields the previous frame intact.
  assign window_d = {lane_i, prev_q};

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_q <= '0;
      lane_q <= '0;
    end else begin
      prev_q <= lane_i;
      lane_q <= mask_i ? '0 : window_d[slip_i +: FRAME_SIZE];
    end
  end

  assign lane_o = lane_q;

endmodule
`default_nettype wire

// File: rtl/sot_frame_aligner_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sot_frame_aligner_gen
//  Purpose  : Per-VFAT S-bit frame aligner. Derives the bitslip from the
//             one-hot SoT frame, qualifies it with a HUNT/VERIFY/LOCKED/
//             HOLDOVER lock machine and word-aligns every S-bit lane.
//  Ports    : clock      - 40 MHz frame clock
//             reset_n_i  - asynchronous active-low reset
//             bus        - slave side of sot_frame_aligner_gen_if (lane data,
//                          SoT, mask, error clear, lock threshold, status)
//  Revision : 1.0  initial release
// ============================================================================
module sot_frame_aligner_gen
  import sot_frame_aligner_gen_pkg::*;
#(
  parameter int FRAME_SIZE = FRAME_SIZE_SDR,
  parameter int NUM_LANES  = 8,
  parameter int SLIP_W     = $clog2(FRAME_SIZE),
  parameter int SOT_OFFSET = 1,
  parameter int MAX_MISS   = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n_i,
  sot_frame_aligner_gen_if.slave  bus
);

  // miss_q only ever holds values below MAX_MISS.
  localparam int MISS_W = (MAX_MISS < 2) ? 1 : $clog2(MAX_MISS);

  lock_state_e           state_q;
  logic [FRAME_SIZE-1:0] sot_q;
  logic [SLIP_W-1:0]     cand_q;
  logic [SLIP_W-1:0]     slip_q;
  logic [11:0]           stable_q;
  logic [MISS_W-1:0]     miss_q;
  logic [ERR_CNT_W-1:0]  err_q;
  logic                  unstable_q;
  logic                  aligned_q;

  onehot_t               sot_oh_d;
  logic                  sot_good_d;
  logic [SLIP_W-1:0]     cand_d;
  logic                  match_d;
  logic                  err_inc_d;
  logic                  unstable_set_d;
  logic                  in_lock_d;
  logic [NUM_LANES*FRAME_SIZE-1:0] lanes_d;

  assign sot_oh_d   = onehot_index(ONEHOT_MAX_W'(sot_q));
  assign sot_good_d = sot_oh_d.valid;
  assign cand_d     = SLIP_W'((int'(sot_oh_d.index) + SOT_OFFSET) % FRAME_SIZE);
  assign match_d    = sot_good_d && (cand_d == slip_q);
  assign in_lock_d  = (state_q == LOCKED) || (state_q == HOLDOVER);

  // While aligned, every non-matching SoT is an error. Lock is lost on a
  // mismatched good SoT, or once the run of bad SoTs reaches MAX_MISS
  // (miss_q is 0 in LOCKED, so the same test covers both states).
  always_comb begin
    err_inc_d      = 1'b0;
    unstable_set_d = 1'b0;
    if (in_lock_d && !match_d) begin
      err_inc_d = 1'b1;
      if (sot_good_d || (int'(miss_q) + 1 >= MAX_MISS)) unstable_set_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= HUNT;
      sot_q      <= '0;
      cand_q     <= '0;
      slip_q     <= '0;
      stable_q   <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      unstable_q <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      sot_q     <= bus.start_of_frame_i;
      aligned_q <= in_lock_d;

      unique case (state_q)
        HUNT: begin
          if (sot_good_d) begin
            if (bus.aligned_count_to_ready_i == 12'd0) begin
              slip_q  <= cand_d;
              state_q <= LOCKED;
            end else begin
              cand_q   <= cand_d;
              stable_q <= '0;
              state_q  <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (sot_good_d && (cand_d == cand_q)) begin
            // Threshold is sampled live, so lowering it mid-run locks at once.
            if ({1'b0, stable_q} + 13'd1 >= {1'b0, bus.aligned_count_to_ready_i}) begin
              slip_q  <= cand_q;
              state_q <= LOCKED;
            end else begin
              stable_q <= stable_q + 12'd1;
            end
          end else begin
            state_q <= HUNT;
          end
        end
        LOCKED, HOLDOVER: begin
          if (match_d) begin
            miss_q  <= '0;
            state_q <= LOCKED;
          end else if (unstable_set_d) begin
            miss_q  <= '0;
            state_q <= HUNT;
          end else begin
            miss_q  <= miss_q + MISS_W'(1);
            state_q <= HOLDOVER;
          end
        end
        default: state_q <= HUNT;
      endcase

      if (bus.clear_err_i)                err_q <= '0;
      else if (err_inc_d && (err_q != '1)) err_q <= err_q + ERR_CNT_W'(1);

      // A same-cycle loss of lock wins over the clear.
      if (unstable_set_d)       unstable_q <= 1'b1;
      else if (bus.clear_err_i) unstable_q <= 1'b0;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sot_frame_aligner_gen_frame_slip_lane #(
      .FRAME_SIZE (FRAME_SIZE),
      .SLIP_W     (SLIP_W)
    ) u_lane (
      .clock     (clock),
      .reset_n_i (reset_n_i),
      .lane_i    (bus.sbits_i[FRAME_SIZE*l +: FRAME_SIZE]),
      .slip_i    (slip_q),
      .mask_i    (bus.mask_i),
      .lane_o    (lanes_d[FRAME_SIZE*l +: FRAME_SIZE])
    );
  end

  // Gated by the registered aligned flag so output zeroing tracks sot_is_aligned_o.
  assign bus.sbits_o          = aligned_q ? lanes_d : '0;
  assign bus.slip_o           = slip_q;
  assign bus.sot_is_aligned_o = aligned_q;
  assign bus.sot_unstable_o   = unstable_q;
  assign bus.sot_err_cnt_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sot_frame_aligner_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sot_frame_aligner_gen
//  Purpose  : Self-checking bench for sot_frame_aligner_gen. An SDR instance
//             (ERR_CNT_W=4) is compared every cycle against a behavioural
//             model; a DDR instance is checked for slip and lane alignment.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_sot_frame_aligner_gen;
  import sot_frame_aligner_gen_pkg::*;

  localparam int FS    = FRAME_SIZE_SDR;
  localparam int NL    = 8;
  localparam int ERR_W = 4;
  localparam int MAXM  = 3;
  localparam int OFFS  = 1;
  localparam int FS2   = FRAME_SIZE_DDR;

  logic clock;
  logic reset_n_i;

  initial clock = 1'b0;
  always #12 clock = ~clock;

  sot_frame_aligner_gen_if #(.FRAME_SIZE(FS),  .NUM_LANES(NL), .ERR_CNT_W(ERR_W)) bus_a ();
  sot_frame_aligner_gen_if #(.FRAME_SIZE(FS2), .NUM_LANES(NL), .ERR_CNT_W(16))    bus_b ();

  sot_frame_aligner_gen #(
    .FRAME_SIZE(FS), .NUM_LANES(NL), .SLIP_W(3), .SOT_OFFSET(OFFS),
    .MAX_MISS(MAXM), .ERR_CNT_W(ERR_W)
  ) dut_sdr (
    .clock     (clock),
    .reset_n_i (reset_n_i),
    .bus       (bus_a.slave)
  );

  sot_frame_aligner_gen #(
    .FRAME_SIZE(FS2), .NUM_LANES(NL), .SLIP_W(4), .SOT_OFFSET(OFFS),
    .MAX_MISS(MAXM), .ERR_CNT_W(16)
  ) dut_ddr (
    .clock     (clock),
    .reset_n_i (reset_n_i),
    .bus       (bus_b.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural reference model (SDR instance) ----------------
  // m_run: 0 while hunting, otherwise how many identical good SoTs seen in a row.
  logic [FS-1:0]    m_sot_r;
  logic [FS-1:0]    m_prev [NL];
  logic [FS*NL-1:0] m_lane;
  bit               m_al, m_al_o, m_unst;
  int               m_run, m_cand, m_slip, m_miss, m_err;

  task automatic model_reset();
    m_sot_r = '0; m_lane = '0;
    for (int l = 0; l < NL; l++) m_prev[l] = '0;
    m_al = 0; m_al_o = 0; m_unst = 0;
    m_run = 0; m_cand = 0; m_slip = 0; m_miss = 0; m_err = 0;
  endtask

  // Advances the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit  good, inc, setu, was_al;
    int  idx, c, n;
    logic [2*FS-1:0] w;
    logic [2*FS-1:0] sh;
    good = ($countones(m_sot_r) == 1);
    idx  = 0;
    for (int i = 0; i < FS; i++) if (m_sot_r[i]) idx = i;
    c    = (idx + OFFS) % FS;
    n    = int'(bus_a.aligned_count_to_ready_i);

    for (int l = 0; l < NL; l++) begin
      w  = {bus_a.sbits_i[FS*l +: FS], m_prev[l]};
      sh = w >> m_slip;
      m_lane[FS*l +: FS] = bus_a.mask_i ? '0 : sh[FS-1:0];
      m_prev[l] = bus_a.sbits_i[FS*l +: FS];
    end

    was_al = m_al; inc = 0; setu = 0;
    if (!m_al) begin
      if (m_run == 0) begin
        if (good) begin
          if (n == 0) begin m_al = 1; m_slip = c; end
          else begin m_run = 1; m_cand = c; end
        end
      end else if (good && c == m_cand) begin
        if (m_run >= n) begin m_al = 1; m_slip = m_cand; m_run = 0; end
        else m_run++;
      end else begin
        m_run = 0;
      end
    end else if (good && c == m_slip) begin
      m_miss = 0;
    end else begin
      inc = 1;
      m_miss++;
      if (good || m_miss >= MAXM) begin
        setu = 1; m_al = 0; m_run = 0; m_miss = 0;
      end
    end

    if (bus_a.clear_err_i)                  m_err = 0;
    else if (inc && m_err < (1 << ERR_W) - 1) m_err++;
    if (setu)                   m_unst = 1;
    else if (bus_a.clear_err_i) m_unst = 0;

    m_al_o  = was_al;
    m_sot_r = bus_a.start_of_frame_i;
  endtask

  task automatic check_a();
    check("slip",     128'(bus_a.slip_o),           128'(m_slip));
    check("aligned",  128'(bus_a.sot_is_aligned_o), 128'(m_al_o));
    check("unstable", 128'(bus_a.sot_unstable_o),   128'(m_unst));
    check("err_cnt",  128'(bus_a.sot_err_cnt_o),    128'(m_err));
    check("sbits",    128'(bus_a.sbits_o),          128'(m_al_o ? m_lane : '0));
  endtask

  // One frame: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic step_a(input logic [FS-1:0] sot, input logic [FS*NL-1:0] data);
    bus_a.start_of_frame_i = sot;
    bus_a.sbits_i          = data;
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    check_a();
    @(negedge clock);
  endtask

  function automatic logic [FS*NL-1:0] count_data(input int base);
    logic [FS*NL-1:0] d;
    for (int l = 0; l < NL; l++) d[FS*l +: FS] = FS'(base * NL + l);
    return d;
  endfunction

  function automatic logic [FS*NL-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic repeat_sot(input logic [FS-1:0] sot, input int cnt);
    for (int i = 0; i < cnt; i++) step_a(sot, rnd_data());
  endtask

  task automatic clear_step(input logic [FS-1:0] sot);
    bus_a.clear_err_i = 1'b1;
    step_a(sot, rnd_data());
    bus_a.clear_err_i = 1'b0;
  endtask

  logic [127:0]  ddr_hist [12];
  logic [FS-1:0] cur_sot;
  logic [FS-1:0] one8;
  int            r;

  initial begin
    reset_n_i = 1'b0;
    bus_a.sbits_i = '0; bus_a.start_of_frame_i = '0; bus_a.mask_i = 1'b0;
    bus_a.clear_err_i = 1'b0; bus_a.aligned_count_to_ready_i = 12'd16;
    bus_b.sbits_i = '0; bus_b.start_of_frame_i = '0; bus_b.mask_i = 1'b0;
    bus_b.clear_err_i = 1'b0; bus_b.aligned_count_to_ready_i = 12'd4;
    model_reset();
    repeat (3) @(negedge clock);
    check_a();
    reset_n_i = 1'b1;

    // Lock on SoT bit 2 with a counting pattern: slip = 3.
    for (int i = 0; i < 20; i++) step_a(8'b0000_0100, count_data(i));
    check("lock_slip",    128'(bus_a.slip_o), 128'd3);
    check("lock_aligned", 128'(bus_a.sot_is_aligned_o), 128'd1);
    check("lock_err",     128'(bus_a.sot_err_cnt_o), 128'd0);

    // Mask zeroes the output without touching lock.
    bus_a.mask_i = 1'b1;
    repeat_sot(8'b0000_0100, 2);
    check("mask_zero",    128'(bus_a.sbits_o), 128'd0);
    check("mask_aligned", 128'(bus_a.sot_is_aligned_o), 128'd1);
    bus_a.mask_i = 1'b0;
    repeat_sot(8'b0000_0100, 2);

    // Holdover: two misses then recovery.
    repeat_sot(8'h00, 2);
    repeat_sot(8'b0000_0100, 3);
    check("hold_aligned", 128'(bus_a.sot_is_aligned_o), 128'd1);
    check("hold_err",     128'(bus_a.sot_err_cnt_o), 128'd2);
    check("hold_unst",    128'(bus_a.sot_unstable_o), 128'd0);

    // Three misses lose lock.
    clear_step(8'b0000_0100);
    repeat_sot(8'h00, 3);
    repeat_sot(8'b0000_0100, 2);
    check("loss_aligned", 128'(bus_a.sot_is_aligned_o), 128'd0);
    check("loss_err",     128'(bus_a.sot_err_cnt_o), 128'd3);
    check("loss_unst",    128'(bus_a.sot_unstable_o), 128'd1);
    check("loss_sbits",   128'(bus_a.sbits_o), 128'd0);

    // Relock at slip 3, then the SoT jumps to bit 7: relock at slip 0.
    repeat_sot(8'b0000_0100, 20);
    clear_step(8'b0000_0100);
    repeat_sot(8'b1000_0000, 22);
    check("jump_slip",    128'(bus_a.slip_o), 128'd0);
    check("jump_aligned", 128'(bus_a.sot_is_aligned_o), 128'd1);
    check("jump_unst",    128'(bus_a.sot_unstable_o), 128'd1);

    // Non-one-hot SoT in the middle of VERIFY restarts the hunt.
    clear_step(8'b1000_0000);
    repeat_sot(8'b0000_0100, 11);
    repeat_sot(8'b0000_0110, 1);
    repeat_sot(8'b0000_0100, 6);
    check("verify_slip",    128'(bus_a.slip_o), 128'd0);
    check("verify_aligned", 128'(bus_a.sot_is_aligned_o), 128'd0);
    repeat_sot(8'b0000_0100, 20);
    check("verify_relock",  128'(bus_a.slip_o), 128'd3);

    // Error counter saturation, then clear with a same-cycle increment pending.
    bus_a.aligned_count_to_ready_i = 12'd0;
    clear_step(8'b0000_0100);
    for (int i = 0; i < 20; i++) begin
      step_a(8'h00, rnd_data());
      step_a(8'b0000_0100, rnd_data());
    end
    check("sat_err", 128'(bus_a.sot_err_cnt_o), 128'd15);
    step_a(8'h00, rnd_data());
    clear_step(8'b0000_0100);
    check("clr_err", 128'(bus_a.sot_err_cnt_o), 128'd0);

    // Randomised traffic.
    one8    = 8'd1;
    cur_sot = 8'b0000_0100;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) cur_sot = one8 << $urandom_range(0, FS - 1);
      bus_a.mask_i      = ($urandom_range(0, 9) == 0);
      bus_a.clear_err_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) bus_a.aligned_count_to_ready_i = 12'($urandom_range(0, 5));
      if (r >= 8 && r < 18)      step_a(8'h00, rnd_data());
      else if (r >= 18 && r < 24) step_a(8'($urandom), rnd_data());
      else                        step_a(cur_sot, rnd_data());
    end
    bus_a.mask_i = 1'b0; bus_a.clear_err_i = 1'b0;

    // Get the SDR instance locked for the reset test.
    bus_a.aligned_count_to_ready_i = 12'd4;
    repeat_sot(8'b0000_0100, 12);
    check("pre_rst_aligned", 128'(bus_a.sot_is_aligned_o), 128'd1);

    // DDR instance: SoT bit 15 gives slip 0, so each lane outputs the previous frame.
    for (int k = 0; k < 12; k++) begin
      ddr_hist[k] = {$urandom, $urandom, $urandom, $urandom};
      bus_b.start_of_frame_i = 16'h8000;
      bus_b.sbits_i          = ddr_hist[k];
      step_a(8'b0000_0100, rnd_data());
      if (k >= 7) check("ddr_sbits", bus_b.sbits_o, ddr_hist[k-1]);
    end
    check("ddr_slip",    128'(bus_b.slip_o), 128'd0);
    check("ddr_aligned", 128'(bus_b.sot_is_aligned_o), 128'd1);

    // Asynchronous reset mid-lock clears every output without a clock edge.
    #5;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check_a();
    check("rst_ddr_sbits",   128'(bus_b.sbits_o), 128'd0);
    check("rst_ddr_slip",    128'(bus_b.slip_o), 128'd0);
    check("rst_ddr_aligned", 128'(bus_b.sot_is_aligned_o), 128'd0);
    @(negedge clock);
    reset_n_i = 1'b1;
    repeat_sot(8'b0000_0100, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
